// File: rtl/jogo_pkg.sv
// Shared state codes and output bundle for the memory-game control unit.
// CONTROLE_TIMEOUT_EN enables the play-timeout path (conta_timeout and fim_timeout).
package jogo_pkg;

  localparam int ESTADO_W                 = 4;
  localparam int INTERVALO_RODADA_PADRAO  = 4;

  // Codes shared with the datapath and the hexa7seg debug display
  localparam logic [ESTADO_W-1:0] COD_INICIAL        = 4'h0;
  localparam logic [ESTADO_W-1:0] COD_PREPARACAO     = 4'h1;
  localparam logic [ESTADO_W-1:0] COD_INICIO_RODADA  = 4'h2;
  localparam logic [ESTADO_W-1:0] COD_ESPERA_JOGADA  = 4'h3;
  localparam logic [ESTADO_W-1:0] COD_REGISTRA       = 4'h4;
  localparam logic [ESTADO_W-1:0] COD_COMPARACAO     = 4'h5;
  localparam logic [ESTADO_W-1:0] COD_PROXIMA_JOGADA = 4'h6;
  localparam logic [ESTADO_W-1:0] COD_PAUSA_RODADA   = 4'h7;
  localparam logic [ESTADO_W-1:0] COD_FIM_ACERTOU    = 4'hA;
  localparam logic [ESTADO_W-1:0] COD_FIM_TIMEOUT    = 4'hD;
  localparam logic [ESTADO_W-1:0] COD_FIM_ERROU      = 4'hE;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL        = COD_INICIAL,
    PREPARACAO     = COD_PREPARACAO,
    INICIO_RODADA  = COD_INICIO_RODADA,
    ESPERA_JOGADA  = COD_ESPERA_JOGADA,
    REGISTRA       = COD_REGISTRA,
    COMPARACAO     = COD_COMPARACAO,
    PROXIMA_JOGADA = COD_PROXIMA_JOGADA,
    PAUSA_RODADA   = COD_PAUSA_RODADA,
    FIM_ACERTOU    = COD_FIM_ACERTOU,
    FIM_TIMEOUT    = COD_FIM_TIMEOUT,
    FIM_ERROU      = COD_FIM_ERROU
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic zera_timeout;
    logic conta_timeout;
    logic pronto;
    logic ganhou;
    logic perdeu;
  } saidas_t;

  // Output decode for a state; primeira_pausa marks the first pausa_rodada cycle.
  function automatic saidas_t decodifica(input estado_t estado, input logic primeira_pausa);
    saidas_t s;
    s = '0;
    case (estado)
      PREPARACAO: begin
        s.zera_l       = 1'b1;
        s.zera_r       = 1'b1;
        s.zera_timeout = 1'b1;
      end
      INICIO_RODADA: begin
        s.zera_e       = 1'b1;
        s.zera_timeout = 1'b1;
      end
`ifdef CONTROLE_TIMEOUT_EN
      ESPERA_JOGADA:  s.conta_timeout = 1'b1;
`endif
      REGISTRA:       s.registra_r = 1'b1;
      PROXIMA_JOGADA: begin
        s.conta_e      = 1'b1;
        s.zera_timeout = 1'b1;
      end
      PAUSA_RODADA:   s.conta_l = primeira_pausa;
      FIM_ACERTOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      FIM_ERROU, FIM_TIMEOUT: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_pausa.sv
// 4-bit pause counter: clear has priority over count, fim_o flags the last pause cycle.
module contador_pausa #(
  parameter int LIMITE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  localparam logic [3:0] VALOR_FIM = 4'(LIMITE - 1);

  logic [3:0] valor_q;
  logic [3:0] valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera_i) begin
      valor_d = '0;
    end else if (conta_i) begin
      valor_d = valor_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim_o = (valor_q == VALOR_FIM);

endmodule

// File: rtl/controle_rodadas_jogo.sv
// Moore round sequencer for the memory game; outputs are registered from the next state.
// CONTROLE_TIMEOUT_EN: when defined, timeout in espera_jogada leads to fim_timeout.
module controle_rodadas_jogo
  import jogo_pkg::*;
#(
  parameter int INTERVALO_RODADA = INTERVALO_RODADA_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zera_timeout,
  output logic       conta_timeout,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t estado_q;
  estado_t estado_d;
  saidas_t saidas_q;
  logic    entra_pausa;
  logic    fim_pausa;
  logic    timeout_efetivo;

`ifdef CONTROLE_TIMEOUT_EN
  assign timeout_efetivo = timeout;
`else
  logic unused_timeout;
  assign unused_timeout  = timeout;
  assign timeout_efetivo = 1'b0;
`endif

  // NOTE: estado_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:        if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:     estado_d = INICIO_RODADA;
      INICIO_RODADA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada) begin
          estado_d = REGISTRA;
        end else if (timeout_efetivo) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual) begin
          estado_d = FIM_ERROU;
        end else if (!fimE) begin
          estado_d = PROXIMA_JOGADA;
        end else if (fimL) begin
          estado_d = FIM_ACERTOU;
        end else begin
          estado_d = PAUSA_RODADA;
        end
      end
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PAUSA_RODADA:   if (fim_pausa) estado_d = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default:        estado_d = INICIAL;
    endcase
  end

  assign entra_pausa = (estado_d == PAUSA_RODADA) && (estado_q != PAUSA_RODADA);

  contador_pausa #(
    .LIMITE (INTERVALO_RODADA)
  ) u_contador_pausa (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (entra_pausa),
    .conta_i (estado_q == PAUSA_RODADA),
    .fim_o   (fim_pausa)
  );

  // Outputs are decoded from the state being entered, so they line up with estado_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= decodifica(estado_d, entra_pausa);
    end
  end

  assign zeraE         = saidas_q.zera_e;
  assign contaE        = saidas_q.conta_e;
  assign zeraL         = saidas_q.zera_l;
  assign contaL        = saidas_q.conta_l;
  assign zeraR         = saidas_q.zera_r;
  assign registraR     = saidas_q.registra_r;
  assign zera_timeout  = saidas_q.zera_timeout;
  assign conta_timeout = saidas_q.conta_timeout;
  assign pronto        = saidas_q.pronto;
  assign ganhou        = saidas_q.ganhou;
  assign perdeu        = saidas_q.perdeu;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_controle_rodadas_jogo.sv
// Directed bench for controle_rodadas_jogo; expected state codes and output vectors are hand-derived.
module tb_controle_rodadas_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, fimE, fimL, timeout;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       zera_timeout, conta_timeout, pronto, ganhou, perdeu;
  logic [3:0] db_estado;
  logic [10:0] saidas_obs;

  int n_vetores = 0;
  int n_erros   = 0;

  // Order: zeraE contaE zeraL contaL zeraR registraR zera_timeout conta_timeout pronto ganhou perdeu
  localparam logic [10:0] S0  = 11'b000_0000_0000;
  localparam logic [10:0] S1  = 11'b001_0101_0000;
  localparam logic [10:0] S2  = 11'b100_0001_0000;
`ifdef CONTROLE_TIMEOUT_EN
  localparam logic [10:0] S3  = 11'b000_0000_1000;
`else
  localparam logic [10:0] S3  = 11'b000_0000_0000;
`endif
  localparam logic [10:0] S4  = 11'b000_0010_0000;
  localparam logic [10:0] S5  = 11'b000_0000_0000;
  localparam logic [10:0] S6  = 11'b010_0001_0000;
  localparam logic [10:0] S7P = 11'b000_1000_0000;
  localparam logic [10:0] S7  = 11'b000_0000_0000;
  localparam logic [10:0] SA  = 11'b000_0000_0110;
  localparam logic [10:0] SE  = 11'b000_0000_0101;

  always #5 clock = ~clock;

  controle_rodadas_jogo dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .jogada        (jogada),
    .igual         (igual),
    .fimE          (fimE),
    .fimL          (fimL),
    .timeout       (timeout),
    .zeraE         (zeraE),
    .contaE        (contaE),
    .zeraL         (zeraL),
    .contaL        (contaL),
    .zeraR         (zeraR),
    .registraR     (registraR),
    .zera_timeout  (zera_timeout),
    .conta_timeout (conta_timeout),
    .pronto        (pronto),
    .ganhou        (ganhou),
    .perdeu        (perdeu),
    .db_estado     (db_estado)
  );

  assign saidas_obs = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                       zera_timeout, conta_timeout, pronto, ganhou, perdeu};

  task automatic confere(input string tag, input logic [10:0] obtido, input logic [10:0] esperado);
    n_vetores++;
    if (obtido !== esperado) begin
      n_erros++;
      $display("FAIL %s: got %b expected %b", tag, obtido, esperado);
    end
  endtask

  // One clock edge, then compare state code and output vector 1 time unit later.
  task automatic passo(input string tag, input logic [3:0] est, input logic [10:0] sai);
    @(posedge clock);
    #1;
    confere({tag, "/estado"}, {7'd0, db_estado}, {7'd0, est});
    confere({tag, "/saidas"}, saidas_obs, sai);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
    fimE = 1'b0; fimL = 1'b0; timeout = 1'b0;

    // 1: reset and start sequence
    passo("reset", 4'h0, S0);
    reset = 1'b0;
    passo("idle", 4'h0, S0);
    iniciar = 1'b1;
    passo("prep", 4'h1, S1);
    iniciar = 1'b0;
    passo("ini_rod", 4'h2, S2);
    passo("espera", 4'h3, S3);
    passo("espera_hold", 4'h3, S3);

    // 2: round 0 completes, pause lasts 4 cycles with contaL only on the first
    fimE = 1'b1; fimL = 1'b0; igual = 1'b1; jogada = 1'b1;
    passo("r0_reg", 4'h4, S4);
    jogada = 1'b0;
    passo("r0_cmp", 4'h5, S5);
    passo("pausa1", 4'h7, S7P);
    passo("pausa2", 4'h7, S7);
    passo("pausa3", 4'h7, S7);
    passo("pausa4", 4'h7, S7);
    passo("r1_ini", 4'h2, S2);
    passo("r1_esp", 4'h3, S3);

    // 3: round 1, two plays, last round -> win; iniciar ignored in 4/5
    fimE = 1'b0; jogada = 1'b1;
    passo("r1a_reg", 4'h4, S4);
    jogada = 1'b0;
    passo("r1a_cmp", 4'h5, S5);
    passo("prox", 4'h6, S6);
    passo("r1b_esp", 4'h3, S3);
    fimE = 1'b1; fimL = 1'b1; jogada = 1'b1;
    passo("r1b_reg", 4'h4, S4);
    jogada = 1'b0; iniciar = 1'b1;
    passo("r1b_cmp", 4'h5, S5);
    passo("ganhou", 4'hA, SA);
    passo("restart", 4'h1, S1);
    iniciar = 1'b0;
    passo("g2_ini", 4'h2, S2);
    passo("g2_esp", 4'h3, S3);

    // 4: wrong play -> fim_errou, later jogada ignored
    igual = 1'b0; jogada = 1'b1;
    passo("err_reg", 4'h4, S4);
    jogada = 1'b0;
    passo("err_cmp", 4'h5, S5);
    passo("errou", 4'hE, SE);
    jogada = 1'b1;
    passo("errou_jog", 4'hE, SE);
    jogada = 1'b0;
    passo("errou_hold", 4'hE, SE);

    // 5: timeout behaviour
    iniciar = 1'b1;
    passo("g3_prep", 4'h1, S1);
    iniciar = 1'b0;
    passo("g3_ini", 4'h2, S2);
    passo("g3_esp", 4'h3, S3);
`ifdef CONTROLE_TIMEOUT_EN
    jogada = 1'b1; timeout = 1'b1; igual = 1'b1; fimE = 1'b0;
    passo("to_prio", 4'h4, S4);
    jogada = 1'b0; timeout = 1'b0;
    passo("to_cmp", 4'h5, S5);
    passo("to_prox", 4'h6, S6);
    passo("to_esp", 4'h3, S3);
    timeout = 1'b1;
    passo("fim_to", 4'hD, SE);
    timeout = 1'b0; iniciar = 1'b1;
    passo("to_restart", 4'h1, S1);
    iniciar = 1'b0;
    passo("to_ini", 4'h2, S2);
    passo("to_esp2", 4'h3, S3);
`else
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      passo("to_ignor", 4'h3, S3);
    end
    timeout = 1'b0;
`endif

    // 6: reset wins mid-round, from state 3 and from state 7
    reset = 1'b1;
    passo("rst_esp", 4'h0, S0);
    reset = 1'b0; iniciar = 1'b1;
    passo("g4_prep", 4'h1, S1);
    iniciar = 1'b0;
    passo("g4_ini", 4'h2, S2);
    passo("g4_esp", 4'h3, S3);
    fimE = 1'b1; fimL = 1'b0; igual = 1'b1; jogada = 1'b1;
    passo("g4_reg", 4'h4, S4);
    jogada = 1'b0;
    passo("g4_cmp", 4'h5, S5);
    passo("g4_pausa1", 4'h7, S7P);
    passo("g4_pausa2", 4'h7, S7);
    reset = 1'b1;
    passo("rst_pausa", 4'h0, S0);
    reset = 1'b0;
    passo("pos_rst", 4'h0, S0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
